multdiv_seq: RTL

- Multi-cycle signed multiply/divide sequencer for the processor's ALU.
- It has one WIDTH-bit carry-lookahead adder, built from 16-bit CLA slices, and uses it every cycle.
- Multiply uses radix-2 Booth. Divide uses non-restoring division with a final sign-fix pass.
- The pipeline stalls on it until data_resultRDY pulses.

---
 rtl/multdiv_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// A single WIDTH-bit carry-lookahead adder is shared by the MUL, DIV and FIX states.

module multdiv_cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_g, w_p;
  logic [16:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Four 4-bit groups; group carries come from group generate/propagate.
  always_comb begin
    logic [16:0] c;
    logic [3:0]  gg, gp;
    c  = '0;
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2]) |
              (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1]) |
              (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      gp[k] = &w_p[4*k +: 4];
    end
    c[0] = i_cin;
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j < 4; j++)
        c[4*k+j] = w_g[4*k+j-1] | (w_p[4*k+j-1] & c[4*k+j-1]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    w_c = c;
  end

  assign o_sum  = w_p ^ w_c[15:0];
  assign o_cout = w_c[16];
endmodule

module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int NS = WIDTH / 16;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_phi, r_plo, r_q, r_bm;
  logic             r_qm1, r_neg, r_dexc;
  logic [WIDTH:0]   r_rem;

  logic [WIDTH-1:0] w_add_a, w_add_b, w_sum;
  logic             w_add_ax, w_add_bx, w_add_cin, w_sumx;
  logic [NS:0]      w_c;
  logic [WIDTH:0]   w_rsh, w_phi_top;
  logic [WIDTH-1:0] w_absA, w_absB;
  logic             w_mexc;

  assign w_absA    = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign w_absB    = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
  assign w_rsh     = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_phi_top = {r_phi, r_plo[WIDTH-1]};
  assign w_mexc    = ~((&w_phi_top) | ~(|w_phi_top));

  // Operand steering for the shared adder; bit WIDTH is a one-bit sign extension.
  always_comb begin
    w_add_a   = '0;
    w_add_ax  = 1'b0;
    w_add_b   = '0;
    w_add_bx  = 1'b0;
    w_add_cin = 1'b0;
    case (r_state)
      S_MUL: begin
        w_add_a  = r_phi;
        w_add_ax = r_phi[WIDTH-1];
        case ({r_plo[0], r_qm1})
          2'b01: begin
            w_add_b  = r_a;
            w_add_bx = r_a[WIDTH-1];
          end
          2'b10: begin
            w_add_b   = ~r_a;
            w_add_bx  = ~r_a[WIDTH-1];
            w_add_cin = 1'b1;
          end
          default: ;
        endcase
      end
      S_DIV: begin
        w_add_a  = w_rsh[WIDTH-1:0];
        w_add_ax = w_rsh[WIDTH];
        if (!r_rem[WIDTH]) begin
          w_add_b   = ~r_bm;
          w_add_bx  = 1'b1;
          w_add_cin = 1'b1;
        end else begin
          w_add_b  = r_bm;
        end
      end
      S_FIX: begin
        w_add_a   = ~r_q;
        w_add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_c[0] = w_add_cin;
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_cla
      multdiv_cla16 u_cla (
        .i_a   (w_add_a[16*gi +: 16]),
        .i_b   (w_add_b[16*gi +: 16]),
        .i_cin (w_c[gi]),
        .o_sum (w_sum[16*gi +: 16]),
        .o_cout(w_c[gi+1])
      );
    end
  endgenerate
  assign w_sumx = w_add_ax ^ w_add_bx ^ w_c[NS];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_a            <= '0;
      r_phi          <= '0;
      r_plo          <= '0;
      r_qm1          <= 1'b0;
      r_rem          <= '0;
      r_q            <= '0;
      r_bm           <= '0;
      r_neg          <= 1'b0;
      r_dexc         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        r_cnt <= '0;
        if (ctrl_MULT) begin
          r_state <= S_MUL;
          r_a     <= data_operandA;
          r_phi   <= '0;
          r_plo   <= data_operandB;
          r_qm1   <= 1'b0;
        end else begin
          r_state <= S_DIV;
          r_rem   <= '0;
          r_q     <= w_absA;
          r_bm    <= w_absB;
          r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          r_dexc  <= (data_operandB == '0) ||
                     ((data_operandA == MINV) && (&data_operandB));
        end
      end else begin
        case (r_state)
          S_MUL: begin
            if (r_cnt == CW'(ITER)) begin
              r_state        <= S_DONE;
              data_result    <= r_plo;
              data_exception <= w_mexc;
              data_resultRDY <= 1'b1;
            end else begin
              r_phi <= {w_sumx, w_sum[WIDTH-1:1]};
              r_plo <= {w_sum[0], r_plo[WIDTH-1:1]};
              r_qm1 <= r_plo[0];
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DIV: begin
            if (r_cnt == CW'(ITER)) begin
              r_state <= S_FIX;
            end else begin
              r_rem <= {w_sumx, w_sum};
              r_q   <= {r_q[WIDTH-2:0], ~w_sumx};
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_FIX: begin
            r_state        <= S_DONE;
            data_exception <= r_dexc;
            data_resultRDY <= 1'b1;
            data_result    <= r_dexc ? '0 : (r_neg ? w_sum : r_q);
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
